// File: rtl/generator_pwm_multicanal_if.sv
// Control/status bundle of the multi-channel PWM generator: run enable, duty
// load path, and the PWM/period/counter outputs.
interface generator_pwm_multicanal_if #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned NUM_CH = 2
);
  logic                      activ;
  logic [NUM_CH*WIDTH-1:0]   duty_in;
  logic                      duty_load;
  logic [NUM_CH-1:0]         pwm_out;
  logic                      period_end;
  logic [WIDTH-1:0]          count_out;

  modport master (
    output activ, duty_in, duty_load,
    input  pwm_out, period_end, count_out
  );

  modport slave (
    input  activ, duty_in, duty_load,
    output pwm_out, period_end, count_out
  );
endinterface

// File: rtl/generator_pwm_multicanal.sv
// Multi-channel PWM: one shared sawtooth counter, shadowed duties applied at the period wrap.
// Optional SOFT_START_EN: active duties ramp toward their target by at most RAMP_STEP per period.
module generator_pwm_multicanal #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned PERIOD    = 1000,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned RAMP_STEP = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  generator_pwm_multicanal_if.slave     bus
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

  if (PERIOD < 2 || (longint'(PERIOD) - 1) >= (longint'(1) << WIDTH)) begin : g_bad_period
    $error("generator_pwm_multicanal: PERIOD-1 must fit in WIDTH bits and PERIOD >= 2");
  end
  if (RAMP_STEP == 0) begin : g_bad_ramp
    $error("generator_pwm_multicanal: RAMP_STEP must be at least 1");
  end

  logic [WIDTH-1:0]  count_q, count_d;
  logic              wrap;
  logic [WIDTH-1:0]  shadow_q   [NUM_CH];
  logic [WIDTH-1:0]  duty_act_q [NUM_CH];
  logic [WIDTH-1:0]  duty_act_d [NUM_CH];
  logic [WIDTH-1:0]  target     [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d;

`ifdef SOFT_START_EN
  // Steps wider than the duty range collapse to "jump straight to target".
  localparam logic [WIDTH:0] STEP = (RAMP_STEP >= (2 ** WIDTH)) ?
                                    {1'b1, {WIDTH{1'b0}}} : (WIDTH+1)'(RAMP_STEP);

  function automatic logic [WIDTH-1:0] ramp(input logic [WIDTH-1:0] cur,
                                            input logic [WIDTH-1:0] tgt);
    logic [WIDTH-1:0] res;
    if (tgt > cur) begin
      res = ({1'b0, tgt - cur} > STEP) ? cur + STEP[WIDTH-1:0] : tgt;
    end else begin
      res = ({1'b0, cur - tgt} > STEP) ? cur - STEP[WIDTH-1:0] : tgt;
    end
    return res;
  endfunction
`endif

  assign wrap = bus.activ && (count_q == LAST);

  always_comb begin
    count_d = count_q + WIDTH'(1);
    if (!bus.activ || wrap) begin
      count_d = '0;
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // A load on the wrap edge bypasses the shadow so it lands this period.
      target[i]     = bus.duty_load ? bus.duty_in[i*WIDTH +: WIDTH] : shadow_q[i];
      duty_act_d[i] = duty_act_q[i];
      if (wrap) begin
`ifdef SOFT_START_EN
        duty_act_d[i] = ramp(duty_act_q[i], target[i]);
`else
        duty_act_d[i] = target[i];
`endif
      end
      pwm_d[i] = bus.activ && (count_q < duty_act_q[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      pwm_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i]   <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      pwm_q      <= pwm_d;
      duty_act_q <= duty_act_d;
      if (bus.duty_load) begin
        for (int i = 0; i < NUM_CH; i++) begin
          shadow_q[i] <= bus.duty_in[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign bus.count_out  = count_q;
  assign bus.pwm_out    = pwm_q;
  assign bus.period_end = wrap;

endmodule

// File: tb/tb_generator_pwm_multicanal.sv
// Directed bench for generator_pwm_multicanal: per-period high-time and
// period_end counts against hand-computed values.
module tb_generator_pwm_multicanal;
  localparam int W = 12;
  localparam int P = 1000;

  logic clock = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  always #10 clock = ~clock;

  generator_pwm_multicanal_if #(.WIDTH(W), .NUM_CH(2)) bus ();

  generator_pwm_multicanal #(
    .WIDTH     (W),
    .PERIOD    (P),
    .NUM_CH    (2),
    .RAMP_STEP (100)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_count(input int v);
    int n = 0;
    while (int'(bus.count_out) != v && n < 3 * P) begin
      tick();
      n++;
    end
    check("wait_count", int'(bus.count_out), v);
  endtask

  // Samples one period aligned so comparisons of counts 0..P-1 are seen;
  // optionally pulses a duty load when the counter shows load_at.
  task automatic measure(input int load_at, input int d0, input int d1,
                         output int h0, output int h1, output int pe);
    h0 = 0;
    h1 = 0;
    pe = 0;
    for (int n = 0; n < P; n++) begin
      h0 += int'(bus.pwm_out[0]);
      h1 += int'(bus.pwm_out[1]);
      pe += int'(bus.period_end);
      if (int'(bus.count_out) == load_at) begin
        bus.duty_in   = {W'(d1), W'(d0)};
        bus.duty_load = 1'b1;
      end
      tick();
      bus.duty_load = 1'b0;
    end
  endtask

  task automatic step(input string tag, input int load_at, input int d0, input int d1,
                      input int e0, input int e1);
    int h0, h1, pe;
    measure(load_at, d0, d1, h0, h1, pe);
    check({tag, "_ch0"}, h0, e0);
    check({tag, "_ch1"}, h1, e1);
    check({tag, "_pe"}, pe, 1);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.activ     = 1'b0;
    bus.duty_load = 1'b0;
    bus.duty_in   = '0;
    tick();
    tick();
    check("rst_count", int'(bus.count_out), 0);
    check("rst_pwm", int'(bus.pwm_out), 0);
    check("rst_pe", int'(bus.period_end), 0);
    reset     = 1'b0;
    bus.activ = 1'b1;
  endtask

  initial begin
    do_reset();
    wait_count(10);
    bus.duty_in   = {W'(P), W'(P)};
`ifdef SOFT_START_EN
    bus.duty_load = 1'b1;
    tick();
    bus.duty_load = 1'b0;
    wait_count(1);
    for (int k = 1; k <= 9; k++) step("ramp_up", -1, 0, 0, 100 * k, 100 * k);
    step("ramp_top", 500, 0, 0, 1000, 1000);
    for (int k = 9; k >= 0; k--) step("ramp_down", -1, 0, 0, 100 * k, 100 * k);
`else
    bus.duty_in   = {W'(750), W'(250)};
    bus.duty_load = 1'b1;
    tick();
    bus.duty_load = 1'b0;
    wait_count(1);
    step("t1_first", -1, 0, 0, 250, 750);
    step("t1_again", 500, 0, 1000, 250, 750);
    step("t2_0_1000", 500, 1000, 4095, 0, 1000);
    step("t2_1000_4095", 500, 4095, 0, 1000, 1000);
    step("t2_4095_0", 500, 500, 500, 1000, 0);
    step("t3_500", 500, 300, 700, 500, 500);
    step("t3_300", 999, 100, 900, 300, 700);
    step("t3_bypass", -1, 0, 0, 100, 900);

    wait_count(400);
    bus.activ = 1'b0;
    tick();
    check("t4_count", int'(bus.count_out), 0);
    check("t4_pwm", int'(bus.pwm_out), 0);
    check("t4_pe", int'(bus.period_end), 0);
    repeat (36) tick();
    check("t4_hold", int'(bus.count_out), 0);
    bus.activ = 1'b1;
    tick();
    check("t4_resume", int'(bus.count_out), 1);
    step("t4_retained", -1, 0, 0, 100, 900);

    step("t5_pre", 500, 800, 800, 100, 900);
    wait_count(600);
    reset = 1'b1;
    tick();
    check("t5_count", int'(bus.count_out), 0);
    check("t5_pwm", int'(bus.pwm_out), 0);
    reset = 1'b0;
    tick();
    step("t5_cleared", -1, 0, 0, 0, 0);
    step("t5_loading", 500, 600, 200, 0, 0);
    step("t5_new", -1, 0, 0, 600, 200);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
